regfile_sb: RTL and testbench

- Parametrised successor to the picoMIPS register file: N-bit × DEPTH-entry storage, dedicated write port, two combinational read ports and two debug taps.
- Adds an asynchronous active-low reset and a per-register busy scoreboard for multi-cycle writers, with an outstanding-reservation counter and a sticky WAW error flag.
- Sits between decode (reads, reservations) and write-back (writes) in the picoMIPS datapath.

---
 rtl/regfile_pkg.sv | 20 ++
 rtl/regfile_scoreboard.sv | 71 +++++++
 rtl/regfile_sb.sv | 100 ++++++++++
 tb/tb_regfile_sb.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types, constants and helpers for the regfile_sb register file and its scoreboard.
package regfile_pkg;

    localparam int REG_AW   = 3;
    localparam int ZERO_REG = 0;
    localparam int POPCNT_W = 64;

    typedef logic [REG_AW-1:0] reg_addr_t;

    // Number of set bits; callers zero-extend narrower vectors to POPCNT_W.
    function automatic logic [6:0] popcount(input logic [POPCNT_W-1:0] v);
        logic [6:0] cnt;
        cnt = 7'd0;
        for (int i = 0; i < POPCNT_W; i++) begin
            cnt = cnt + {6'd0, v[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy scoreboard for regfile_sb: per-register busy bits, outstanding count and sticky WAW flag.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             n_reset,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic             rsv,
    input  logic [AW-1:0]    rsv_addr,
    output logic [DEPTH-1:0] busy,
    output logic [AW:0]      pend_cnt,
    output logic             waw_err
);

    localparam logic [AW-1:0] ZERO_A = AW'(ZERO_REG);

    logic [DEPTH-1:0] busy_q, busy_d;
    logic [AW:0]      pend_q, pend_d;
    logic             waw_q, waw_d;
    logic             wr_hit_s, rsv_hit_s;

    // Next-state: write clears busy first, so a same-cycle reservation wins.
    always_comb begin
        busy_d    = busy_q;
        waw_d     = waw_q;
        wr_hit_s  = we  && (waddr    != ZERO_A);
        rsv_hit_s = rsv && (rsv_addr != ZERO_A);

        if (wr_hit_s) begin
            busy_d[waddr] = 1'b0;
        end else begin
            busy_d = busy_q;
        end

        if (rsv_hit_s) begin
            busy_d[rsv_addr] = 1'b1;
        end else begin
            busy_d[0] = 1'b0;
        end

        if (rsv_hit_s && busy_q[rsv_addr] && !(wr_hit_s && (waddr == rsv_addr))) begin
            waw_d = 1'b1;
        end else begin
            waw_d = waw_q;
        end

        pend_d = (AW+1)'(popcount(POPCNT_W'(busy_d)));
    end

    // Scoreboard state registers.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            busy_q <= {DEPTH{1'b0}};
            pend_q <= {(AW+1){1'b0}};
            waw_q  <= 1'b0;
        end else begin
            busy_q <= busy_d;
            pend_q <= pend_d;
            waw_q  <= waw_d;
        end
    end

    assign busy     = busy_q;
    assign pend_cnt = pend_q;
    assign waw_err  = waw_q;

endmodule

// File: rtl/regfile_sb.sv
// picoMIPS register file with busy scoreboard, two read ports and two debug taps.
// Define REGFILE_SB_BYPASS_EN for same-cycle write-through on the read ports.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int N     = 8,
    parameter int DEPTH = 8,
    parameter int TAP0  = 3,
    parameter int TAP1  = 5,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                n_reset,
    input  logic                we,
    input  logic [AW-1:0]       waddr,
    input  logic [N-1:0]        wdata,
    input  logic [AW-1:0]       raddr1,
    input  logic [AW-1:0]       raddr2,
    output logic signed [N-1:0] rdata1,
    output logic signed [N-1:0] rdata2,
    output logic                rbusy1,
    output logic                rbusy2,
    input  logic                rsv,
    input  logic [AW-1:0]       rsv_addr,
    output logic [AW:0]         pend_cnt,
    output logic                waw_err,
    output logic signed [N-1:0] tap0,
    output logic signed [N-1:0] tap1
);

    localparam logic [AW-1:0] ZERO_A = AW'(ZERO_REG);
    localparam logic [AW-1:0] TAP0_A = AW'(TAP0);
    localparam logic [AW-1:0] TAP1_A = AW'(TAP1);

    logic [N-1:0]     regs_q [DEPTH];
    logic [DEPTH-1:0] busy_s;
    logic             wr_hit_s;
    logic [N-1:0]     rdata1_s, rdata2_s;
    logic             rbusy1_s, rbusy2_s;

    assign wr_hit_s = we && (waddr != ZERO_A);

    regfile_scoreboard #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_sb (
        .clk      (clk),
        .n_reset  (n_reset),
        .we       (we),
        .waddr    (waddr),
        .rsv      (rsv),
        .rsv_addr (rsv_addr),
        .busy     (busy_s),
        .pend_cnt (pend_cnt),
        .waw_err  (waw_err)
    );

    // Storage array; register 0 is never written and stays zero.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= {N{1'b0}};
            end
        end else begin
            if (wr_hit_s) begin
                regs_q[waddr] <= wdata;
            end
        end
    end

    // Combinational read ports with optional write-through.
    always_comb begin
        rdata1_s = (raddr1 == ZERO_A) ? {N{1'b0}} : regs_q[raddr1];
        rdata2_s = (raddr2 == ZERO_A) ? {N{1'b0}} : regs_q[raddr2];
        rbusy1_s = busy_s[raddr1];
        rbusy2_s = busy_s[raddr2];
`ifdef REGFILE_SB_BYPASS_EN
        if (wr_hit_s && (raddr1 == waddr)) begin
            rdata1_s = wdata;
            rbusy1_s = 1'b0;
        end else begin
            rbusy1_s = busy_s[raddr1];
        end
        if (wr_hit_s && (raddr2 == waddr)) begin
            rdata2_s = wdata;
            rbusy2_s = 1'b0;
        end else begin
            rbusy2_s = busy_s[raddr2];
        end
`endif
    end

    assign rdata1 = rdata1_s;
    assign rdata2 = rdata2_s;
    assign rbusy1 = rbusy1_s;
    assign rbusy2 = rbusy2_s;
    assign tap0   = (TAP0_A == ZERO_A) ? {N{1'b0}} : regs_q[TAP0_A];
    assign tap1   = (TAP1_A == ZERO_A) ? {N{1'b0}} : regs_q[TAP1_A];

endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb (default parameters).
module tb_regfile_sb;

    logic              clk = 1'b0;
    logic              n_reset;
    logic              we;
    logic [2:0]        waddr;
    logic [7:0]        wdata;
    logic [2:0]        raddr1, raddr2;
    logic signed [7:0] rdata1, rdata2;
    logic              rbusy1, rbusy2;
    logic              rsv;
    logic [2:0]        rsv_addr;
    logic [3:0]        pend_cnt;
    logic              waw_err;
    logic signed [7:0] tap0, tap1;

    int checks   = 0;
    int failures = 0;

    regfile_sb dut (
        .clk      (clk),
        .n_reset  (n_reset),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .raddr1   (raddr1),
        .raddr2   (raddr2),
        .rdata1   (rdata1),
        .rdata2   (rdata2),
        .rbusy1   (rbusy1),
        .rbusy2   (rbusy2),
        .rsv      (rsv),
        .rsv_addr (rsv_addr),
        .pend_cnt (pend_cnt),
        .waw_err  (waw_err),
        .tap0     (tap0),
        .tap1     (tap1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we = 1'b0; rsv = 1'b0;
    endtask

    task automatic pulse_reset();
        #3 n_reset = 1'b0;
        #1;
    endtask

    initial begin
        n_reset = 1'b0; we = 1'b0; waddr = 3'd0; wdata = 8'h00;
        raddr1 = 3'd0; raddr2 = 3'd0; rsv = 1'b0; rsv_addr = 3'd0;
        repeat (2) tick();
        check("rst_pend", {4'd0, pend_cnt}, 8'd0);
        check("rst_waw", {7'd0, waw_err}, 8'd0);
        check("rst_tap0", tap0, 8'h00);
        n_reset = 1'b1;

        // Preload r1..r7 with 0x11..0x17
        for (int i = 1; i < 8; i++) begin
            we = 1'b1; waddr = 3'(i); wdata = 8'(8'h10 + i);
            tick();
        end
        idle();
        rsv = 1'b1; rsv_addr = 3'd2; tick();
        rsv = 1'b1; rsv_addr = 3'd2; tick();
        idle();
        raddr1 = 3'd3; raddr2 = 3'd2;
        #1;
        check("pre_tap0", tap0, 8'h13);
        check("pre_tap1", tap1, 8'h15);
        check("pre_rd1", rdata1, 8'h13);
        check("pre_busy2", {7'd0, rbusy2}, 8'd1);
        check("pre_pend", {4'd0, pend_cnt}, 8'd1);
        check("pre_waw", {7'd0, waw_err}, 8'd1);

        // Mid-cycle asynchronous reset
        pulse_reset();
        check("arst_tap0", tap0, 8'h00);
        check("arst_tap1", tap1, 8'h00);
        check("arst_rd1", rdata1, 8'h00);
        check("arst_busy2", {7'd0, rbusy2}, 8'd0);
        check("arst_pend", {4'd0, pend_cnt}, 8'd0);
        check("arst_waw", {7'd0, waw_err}, 8'd0);
        #2 n_reset = 1'b1;
        tick();

        // Write/read
        we = 1'b1; waddr = 3'd3; wdata = 8'h5A; raddr1 = 3'd3;
        tick();
        idle();
        check("wr_rd1", rdata1, 8'h5A);
        check("wr_tap0", tap0, 8'h5A);
        we = 1'b1; waddr = 3'd0; wdata = 8'hFF; raddr2 = 3'd0;
        tick();
        idle();
        check("wr_r0", rdata2, 8'h00);
        check("wr_r0_busy", {7'd0, rbusy2}, 8'd0);

        // Scoreboard
        rsv = 1'b1; rsv_addr = 3'd4; tick();
        rsv = 1'b1; rsv_addr = 3'd6; tick();
        rsv = 1'b1; rsv_addr = 3'd0; tick();
        idle();
        raddr1 = 3'd4;
        #1;
        check("sb_pend2", {4'd0, pend_cnt}, 8'd2);
        check("sb_busy4", {7'd0, rbusy1}, 8'd1);
        check("sb_waw0", {7'd0, waw_err}, 8'd0);
        we = 1'b1; waddr = 3'd4; wdata = 8'h11;
        tick();
        idle();
        check("sb_clr_busy", {7'd0, rbusy1}, 8'd0);
        check("sb_pend1", {4'd0, pend_cnt}, 8'd1);
        check("sb_rd4", rdata1, 8'h11);

        // Simultaneous write and reserve of a busy register
        rsv = 1'b1; rsv_addr = 3'd2; tick();
        idle();
        check("sim_pend_pre", {4'd0, pend_cnt}, 8'd2);
        we = 1'b1; waddr = 3'd2; wdata = 8'h22; rsv = 1'b1; rsv_addr = 3'd2; raddr2 = 3'd2;
        tick();
        idle();
        check("sim_data", rdata2, 8'h22);
        check("sim_busy", {7'd0, rbusy2}, 8'd1);
        check("sim_pend", {4'd0, pend_cnt}, 8'd2);
        check("sim_waw", {7'd0, waw_err}, 8'd0);

        // WAW from a clean state
        pulse_reset();
        #2 n_reset = 1'b1;
        tick();
        rsv = 1'b1; rsv_addr = 3'd5; tick();
        check("waw_first", {7'd0, waw_err}, 8'd0);
        rsv = 1'b1; rsv_addr = 3'd5; tick();
        idle();
        check("waw_set", {7'd0, waw_err}, 8'd1);
        check("waw_pend", {4'd0, pend_cnt}, 8'd1);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("waw_hold", {7'd0, waw_err}, 8'd1);
        end

        // Write-through behaviour on r7
        we = 1'b1; waddr = 3'd7; wdata = 8'h33; rsv = 1'b1; rsv_addr = 3'd7; raddr1 = 3'd7;
        tick();
        idle();
        check("bp_old_data", rdata1, 8'h33);
        check("bp_old_busy", {7'd0, rbusy1}, 8'd1);
        we = 1'b1; waddr = 3'd7; wdata = 8'h80;
        #1;
`ifdef REGFILE_SB_BYPASS_EN
        check("bp_same_data", rdata1, 8'h80);
        check("bp_same_busy", {7'd0, rbusy1}, 8'd0);
`else
        check("bp_same_data", rdata1, 8'h33);
        check("bp_same_busy", {7'd0, rbusy1}, 8'd1);
`endif
        check("bp_tap_old", tap1, 8'h00);
        tick();
        idle();
        check("bp_after_data", rdata1, 8'h80);
        check("bp_after_busy", {7'd0, rbusy1}, 8'd0);
        check("bp_after_pend", {4'd0, pend_cnt}, 8'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
